// File: rtl/ecc_rd_pkg.sv
// Shared types and constants for the GF(2^233) result reader and its multiplier core.
package ecc_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_SEND
    } rd_state_t;

    localparam int unsigned FIELD_W         = 233;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_COORD = 8;
    localparam int unsigned NUM_WORDS       = 16;
    localparam int unsigned COORD_W         = WORD_W * WORDS_PER_COORD;

    // Curve B-233 parameters (y^2 + xy = x^3 + a*x^2 + b) and its base point.
    localparam logic [FIELD_W-1:0] CURVE_A = 233'h1;
    localparam logic [FIELD_W-1:0] CURVE_B =
        233'h066647EDE6C332C7F8C0923BB58213B333B20E9CE4281FE115F7D8F90AD;
    localparam logic [FIELD_W-1:0] BASE_X  =
        233'h0FAC9DFCBAC8313BB2139F1BB755FEF65BC391F8B36F8F8EB7371FD558B;
    localparam logic [FIELD_W-1:0] BASE_Y  =
        233'h1006A08A41903350678E58528BEBF8A0BEFF867A7CA36716F7E01F81052;

endpackage

// File: rtl/ecc_rd_wordsel.sv
// 16:1 result word select: words 0..7 come from xr, 8..15 from yr, LS word first.
module ecc_rd_wordsel
    import ecc_rd_pkg::*;
(
    input  logic [COORD_W-1:0] xr,
    input  logic [COORD_W-1:0] yr,
    input  logic [3:0]         idx,
    output logic [WORD_W-1:0]  data
);

    logic [2*COORD_W-1:0] both;

    always_comb begin
        both = {yr, xr};
        data = both[idx*WORD_W +: WORD_W];
    end

endmodule

// File: rtl/ecc_result_reader.sv
// Loads a scalar into the point multiplier, waits for completion and streams x/y as 16 words.
// Optional RUN watchdog with err pulse: define ECC_RD_TIMEOUT_EN.
module ecc_result_reader
    import ecc_rd_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_key,
    output logic [31:0]        key,
    output logic               mul_reset_n,
    input  logic               mul_done,
    input  logic [FIELD_W-1:0] x_final,
    input  logic [FIELD_W-1:0] y_final,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_last,
    output logic               err
);

    rd_state_t          state, state_nxt;
    logic [3:0]         load_cnt;
    logic [3:0]         idx;
    logic [COORD_W-1:0] xr, yr;
    logic               accept, load_done, capture, beat, burst_end, timeout;

`ifdef ECC_RD_TIMEOUT_EN
    logic [9:0] run_cnt;
    logic       err_q;

    assign timeout = (state == ST_RUN) && !mul_done
                     && (run_cnt == 10'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state != ST_RUN)
                run_cnt <= '0;
            else if (!mul_done)
                run_cnt <= run_cnt + 10'd1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        accept    = (state == ST_IDLE) && cmd_valid;
        load_done = (state == ST_LOAD) && (load_cnt == 4'(RESET_CYCLES - 1));
        capture   = (state == ST_RUN) && mul_done;
        beat      = (state == ST_SEND) && out_ready;
        burst_end = beat && (idx == 4'(NUM_WORDS - 1));
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)    state_nxt = ST_LOAD;
            ST_LOAD: if (load_done) state_nxt = ST_RUN;
            ST_RUN: begin
                if (capture)        state_nxt = ST_SEND;
                else if (timeout)   state_nxt = ST_IDLE;
            end
            ST_SEND: if (burst_end) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // idx wraps to 0 on the word-15 handshake, so the next burst needs no extra clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key      <= '0;
            load_cnt <= '0;
            idx      <= '0;
            xr       <= '0;
            yr       <= '0;
        end else begin
            if (accept) begin
                key      <= cmd_key;
                load_cnt <= '0;
            end
            if (state == ST_LOAD)
                load_cnt <= load_cnt + 4'd1;
            if (capture) begin
                xr  <= {{(COORD_W - FIELD_W){1'b0}}, x_final};
                yr  <= {{(COORD_W - FIELD_W){1'b0}}, y_final};
                idx <= '0;
            end
            if (beat)
                idx <= idx + 4'd1;
        end
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign mul_reset_n = (state == ST_RUN) || (state == ST_SEND);
    assign out_valid   = (state == ST_SEND);
    assign out_last    = (state == ST_SEND) && (idx == 4'(NUM_WORDS - 1));

    ecc_rd_wordsel u_wordsel (
        .xr   (xr),
        .yr   (yr),
        .idx  (idx),
        .data (out_data)
    );

endmodule

// File: tb/tb_ecc_result_reader.sv
// Randomized self-checking bench for ecc_result_reader against a word-level reference model.
module tb_ecc_result_reader;

    localparam int RC = 2;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_key;
    logic [31:0]  key;
    logic         mul_reset_n;
    logic         mul_done;
    logic [232:0] x_final;
    logic [232:0] y_final;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ecc_result_reader #(
        .RESET_CYCLES   (RC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_key     (cmd_key),
        .key         (key),
        .mul_reset_n (mul_reset_n),
        .mul_done    (mul_done),
        .x_final     (x_final),
        .y_final     (y_final),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err         (err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result stream is x then y, each zero-extended to 256 bits, LS word first.
    function automatic logic [31:0] model_word(input logic [232:0] x, input logic [232:0] y, input int n);
        logic [255:0] c;
        c = (n < 8) ? {23'b0, x} : {23'b0, y};
        return c[(n % 8) * 32 +: 32];
    endfunction

    function automatic logic [232:0] rand233();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t[232:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ready_mode: 0 always ready, 1 alternating 1/0, 2 random. abort_at<16 resets mid-burst.
    task automatic run_op(input logic [31:0] k, input logic [232:0] x, input logic [232:0] y,
                          input int run_wait, input int ready_mode, input bit early,
                          input bit busy, input int abort_at);
        int cnt, cyc, n;
        bit hold_ok, rdy;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_key   = k;
        x_final   = rand233();
        y_final   = rand233();
        mul_done  = 1'b0;
        tick();
        check("key_load", key, k);
        cmd_valid = busy;
        cmd_key   = busy ? 32'hFFFF_FFFF : $urandom;
        if (early) mul_done = 1'b1;
        hold_ok = 1'b1;
        cnt = 0;
        while (mul_reset_n === 1'b0 && cnt < 40) begin
            if (cmd_ready !== 1'b0 || key !== k || out_valid !== 1'b0) hold_ok = 1'b0;
            cnt++;
            tick();
        end
        check("load_cycles", cnt, RC);
        for (int i = 0; i < run_wait; i++) begin
            if (out_valid !== 1'b0 || mul_reset_n !== 1'b1 || cmd_ready !== 1'b0 || key !== k || err !== 1'b0)
                hold_ok = 1'b0;
            tick();
        end
        check("run_no_valid", out_valid, 0);
        mul_done = 1'b1;
        x_final  = x;
        y_final  = y;
        tick();
        mul_done = 1'($urandom_range(0, 1));
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 100) begin
            check("valid", out_valid, 1);
            check($sformatf("word%0d", n), out_data, model_word(x, y, n));
            check($sformatf("last%0d", n), out_last, n == 15);
            if (cmd_ready !== 1'b0 || key !== k || mul_reset_n !== 1'b1) hold_ok = 1'b0;
            if (n == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_valid", out_valid, 0);
                check("abort_mul_reset_n", mul_reset_n, 0);
                check("abort_cmd_ready", cmd_ready, 1);
                check("abort_last", out_last, 0);
                check("abort_data", out_data, 0);
                check("abort_key", key, 0);
                #1;
                reset     = 1'b0;
                out_ready = 1'b0;
                mul_done  = 1'b0;
                tick();
                return;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            x_final   = rand233();
            y_final   = rand233();
            tick();
            if (rdy) n++;
            cyc++;
        end
        out_ready = 1'b0;
        mul_done  = 1'b0;
        check("word_count", n, 16);
        if (ready_mode == 0) check("burst_len", cyc, 16);
        if (ready_mode == 1) check("burst_len_bp", cyc, 31);
        check("cmd_ready_after", cmd_ready, 1);
        check("valid_after", out_valid, 0);
        check("mul_reset_n_after", mul_reset_n, 0);
        check("err_after", err, 0);
        check("hold_during_op", hold_ok, 1);
    endtask

`ifdef ECC_RD_TIMEOUT_EN
    task automatic timeout_op();
        int cnt;
        bit seen;
        check("to_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_key   = $urandom;
        mul_done  = 1'b0;
        tick();
        cmd_valid = 1'b0;
        cnt = 0;
        seen = 1'b0;
        while (mul_reset_n === 1'b0 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("to_load_cycles", cnt, RC);
        cnt = 0;
        while (mul_reset_n === 1'b1 && cnt < 200) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            cnt++;
            tick();
        end
        check("to_run_cycles", cnt, TO);
        check("to_err_pulse", err, 1);
        check("to_idle", cmd_ready, 1);
        check("to_no_valid_now", out_valid, 0);
        tick();
        check("to_err_one_cycle", err, 0);
        check("to_no_words", seen, 0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_ecc_result_reader watchdog");
    end

    initial begin
        logic [232:0] xs;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_key   = '0;
        mul_done  = 1'b0;
        x_final   = '0;
        y_final   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_key", key, 0);
        check("rst_mul_reset_n", mul_reset_n, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);
        #10;
        reset = 1'b0;
        tick();

        xs = '0;
        xs[232] = 1'b1;
        xs[7:0] = 8'hAB;
        run_op(32'h8000_0001, xs, 233'h0CD, 40, 0, 1'b0, 1'b0, 16);
        run_op($urandom, rand233(), rand233(), 5, 1, 1'b0, 1'b0, 16);
        run_op($urandom, rand233(), rand233(), 3, 0, 1'b0, 1'b1, 16);
        run_op(32'hFFFF_FFFF, rand233(), rand233(), 2, 0, 1'b0, 1'b0, 16);
        run_op($urandom, rand233(), rand233(), 0, 0, 1'b1, 1'b0, 16);
        run_op($urandom, rand233(), rand233(), 4, 0, 1'b0, 1'b0, 5);
        run_op($urandom, rand233(), rand233(), 1, 0, 1'b0, 1'b0, 16);
`ifdef ECC_RD_TIMEOUT_EN
        timeout_op();
`else
        run_op($urandom, rand233(), rand233(), 60, 0, 1'b0, 1'b0, 16);
`endif
        for (int i = 0; i < 6; i++)
            run_op($urandom, rand233(), rand233(), $urandom_range(0, 30), 2, 1'b0, 1'b0, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecc_result_reader.md
# ecc_result_reader

Host-side companion to the GF(2^233) scalar point multiplier. The block accepts a 32-bit scalar over a valid/ready command port and loads it into the multiplier by holding the multiplier's active-low reset with the key stable. It then waits for `mul_done`, captures `x_final`/`y_final`, and streams both coordinates out as sixteen 32-bit words over a valid/ready result port. It sits between the bus-facing host logic and the multiplier core.

## Interface
- `RESET_CYCLES`, default 2: cycles `mul_reset_n` is held low in LOAD; legal range 1..15.
- `TIMEOUT_CYCLES`, default 1023: RUN watchdog limit. Used only with `ECC_RD_TIMEOUT_EN`.
- `clk`  in  1  system clock. All state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  host offers a scalar.
- `cmd_ready`  out  1  block accepts a scalar; high only in IDLE.
- `cmd_key`  in  32  scalar, sampled on the command handshake.
- `key`  out  32  registered scalar driven to the multiplier's `key` input.
- `mul_reset_n`  out  1  drives the multiplier's active-low `reset`; high only in RUN and SEND.
- `mul_done`  in  1  multiplier completion level.
- `x_final`, `y_final`  in  233 each  multiplier affine result.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  consumer accepts a word.
- `out_data`  out  32  result word.
- `out_last`  out  1  high with word 15.
- `err`  out  1  one-cycle timeout pulse.

## Operation
- States: IDLE, LOAD, RUN, SEND.
- IDLE
  - `cmd_ready`=1 and `mul_reset_n`=0.
  - On `cmd_valid&&cmd_ready`: `key`<=`cmd_key`, load counter cleared, go to LOAD.
- LOAD
  - `mul_reset_n`=0 for exactly RESET_CYCLES cycles, then go to RUN.
  - `mul_done` is ignored.
- RUN
  - `mul_reset_n`=1.
  - On the first cycle `mul_done` is sampled high: capture `x_final` into xr[255:0] and `y_final` into yr[255:0`], with bits 255:233 forced to 0. Clear the word index and go to SEND.
- SEND
  - `out_valid`=1.
  - `out_data` = word[idx], where word 0..7 = xr[32i+31:32i] and word 8..15 = yr[32(i-8)+31:32(i-8)]. Least-significant word goes first.
  - `idx` increments on each `out_valid&&out_ready`.
  - `out_last`=(idx==15).
  - After the handshake on word 15, go to IDLE.
  - `mul_reset_n` stays 1 so the multiplier holds its final state.
- While `out_valid` is high and `out_ready` is low, `out_data`/`out_last` hold stable.
- `cmd_valid` outside IDLE is not accepted. It does not abort an operation in progress.
- Changes on `mul_done`, `x_final` or `y_final` after capture have no effect.

## Timing
- Async reset values:
  - state = IDLE, `cmd_ready`=1, `key`=0, `mul_reset_n`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `err`=0, idx=0.
  - xr/yr=0.
- Command accepted at edge T:
  - `mul_reset_n` is low for edges T+1..T+RESET_CYCLES.
  - `mul_reset_n` is high from the cycle after the last LOAD edge.
- `mul_done` sampled high at edge D → `out_valid`=1 from the cycle after D.
- Minimum result burst: 16 cycles with `out_ready` tied high.
- `cmd_ready` returns high on the cycle after the word-15 handshake.
- Reset mid-operation: outputs return to reset values immediately, and any partial burst is discarded.
- All outputs are registered or decoded directly from state. There are no combinational paths from `out_ready` or `cmd_valid` to any output.

## Configuration
- `ECC_RD_TIMEOUT_EN` defined:
  - A 10-bit RUN cycle counter is present.
  - If the counter reaches TIMEOUT_CYCLES without `mul_done`, the block goes to IDLE with `mul_reset_n`=0 and pulses `err` for one cycle.
  - No words are emitted in that case.
- `ECC_RD_TIMEOUT_EN` undefined:
  - RUN waits indefinitely.
  - `err` is tied to 0 and the counter is absent.

## Structure
- Package `ecc_rd_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, SEND);
  - FIELD_W=233, WORD_W=32, WORDS_PER_COORD=8, NUM_WORDS=16;
  - the multiplier base-point and curve constants shared with the core.
- One sub-module, `ecc_rd_wordsel`: combinational 16:1 word select from xr/yr by a 4-bit idx, producing `out_data`.

## Test plan
- Normal run: accept `cmd_key`=0x8000_0001; model asserts `mul_done` 40 cycles into RUN with `x_final`=233'h1_0000…00AB and `y_final`=233'h0CD, `out_ready`=1.
  - Expect `key`=0x8000_0001 and `mul_reset_n` low for 2 cycles.
  - Word 0 = 0x0000_00AB; word 7 = 0x0000_0100; word 8 = 0x0000_00CD.
  - `out_last` high only on word 15; `cmd_ready` high on the next cycle.
- Backpressure: `out_ready` alternates 1/0.
  - Expect 16 distinct words in order, each held stable while stalled, 31 cycles total.
- Command during busy: `cmd_valid` held high through RUN/SEND with `cmd_key`=0xFFFF_FFFF.
  - Expect no acceptance until IDLE; then `key` updates once.
- Early done: `mul_done`=1 during LOAD, then held.
  - Expect capture only on the first RUN cycle, never in LOAD.
- Timeout (`ECC_RD_TIMEOUT_EN`, TIMEOUT_CYCLES=20): `mul_done` never asserted.
  - Expect `err` pulse after 20 RUN cycles, IDLE, `out_valid` never high.
- Reset at word 5 of SEND.
  - Expect `out_valid`=0, `mul_reset_n`=0, `cmd_ready`=1 immediately.
  - The next command runs a full 16-word burst starting at word 0.
